// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between the MIPS memory stage and a word-addressed data
//   RAM. Byte addresses become word indices. Byte and halfword loads are
//   sign- or zero-extended. Byte and halfword stores are read-modify-write,
//   because the RAM only writes whole words.
//
//   Ports
//     clk, rst        clock (rising edge), asynchronous active-low reset
//     req / ready     request handshake; accepted when req && ready
//     we, addr, wdata store flag, byte address, right-aligned store data
//     size, sign_ext  00 byte, 01 half, 1x word; load extension select
//     done, rdata     one-cycle completion pulse, extended load result
//     err             misalignment trap flag, valid with done
//     mem_a, mem_wd   RAM word index and write data
//     mem_we          RAM write enable
//     mem_rd          RAM combinational read data
//
//   Build option
//     MISALIGN_TRAP_EN  When defined, a misaligned half or word access is not
//                       performed. It completes at once with err=1.
//                       When undefined, the low address bits are forced to zero.
module mem_access_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   output logic             ready,
   input  logic             we,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [1:0]       size,
   input  logic             sign_ext,
   output logic             done,
   output logic [WIDTH-1:0] rdata,
   output logic             err,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_rd
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [AW+1:0]    addr_q, addr_d;   // only index + lane bits are ever used
   logic             we_q, we_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]       size_q, size_d;
   logic             sext_q, sext_d;
   logic [WIDTH-1:0] rbuf_q, rbuf_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [1:0]       lo_mask;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] st_merge;

   // Half ignores addr[0] and word ignores addr[1:0]. With the trap enabled,
   // misaligned requests never reach the RAM, so this forcing is harmless.
   always_comb begin
      case (size)
         2'b00:   lo_mask = 2'b11;
         2'b01:   lo_mask = 2'b10;
         default: lo_mask = 2'b00;
      endcase
   end

   // Load extraction works straight off the RAM read port during RD.
   always_comb begin
      byte_v = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (size_q)
         2'b00:   ld_val = sext_q ? {{(WIDTH-8){byte_v[7]}}, byte_v}
                                  : {{(WIDTH-8){1'b0}}, byte_v};
         2'b01:   ld_val = sext_q ? {{(WIDTH-16){half_v[15]}}, half_v}
                                  : {{(WIDTH-16){1'b0}}, half_v};
         default: ld_val = mem_rd;
      endcase
   end

   // Sub-word store: the word captured in RD with the target lane(s) replaced.
   always_comb begin
      st_merge = rbuf_q;
      case (size_q)
         2'b00:   st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: st_merge = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = {addr[AW+1:2], addr[1:0] & lo_mask};
               we_d    = we;
               wdata_d = wdata;
               size_d  = size;
               sext_d  = sign_ext;
               err_d   = 1'b0;
               // A word store needs no old data. Everything else reads first.
               state_d = (we && size[1]) ? S_WR : S_RD;
`ifdef MISALIGN_TRAP_EN
               if ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00)) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
`endif
            end
         end
         S_RD: begin
            rbuf_d = mem_rd;
            if (we_q) begin
               state_d = S_WR;
            end else begin
               rdata_d = ld_val;
               state_d = S_RESP;
            end
         end
         S_WR:    state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // The outputs are decoded from state. A reset therefore drops mem_we
   // immediately, and no partial write is committed.
   assign ready  = (state_q == S_IDLE);
   assign done   = (state_q == S_RESP);
   assign mem_we = (state_q == S_WR);
   assign mem_wd = mem_we ? st_merge : '0;
   assign mem_a  = {{(WIDTH-AW){1'b0}}, addr_q[AW+1:2]};
   assign rdata  = rdata_q;
`ifdef MISALIGN_TRAP_EN
   assign err    = done & err_q;
`else
   assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  size = 2'b00;
   logic        ready, done, err, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;

   mem_access_unit #(.WIDTH(32), .DEPTH(32)) dut (
      .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .addr(addr),
      .wdata(wdata), .size(size), .sign_ext(sign_ext), .done(done),
      .rdata(rdata), .err(err), .mem_a(mem_a), .mem_wd(mem_wd),
      .mem_we(mem_we), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return 32'h1357_9BDF ^ (i * 32'h0101_0101);
   endfunction

   // The bench RAM is filled with a known pattern while init_en is high.
   logic        init_en = 1'b1;
   logic [31:0] ram [32];
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 32; i++) ram[i] <= pat(i);
      end else if (mem_we) begin
         ram[mem_a[4:0]] <= mem_wd;
      end
   end
   assign mem_rd = ram[mem_a[4:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else passed++;
   endtask

   typedef struct { logic [31:0] rd; logic er; int lat; int acc; } item_t;
   typedef struct { logic [31:0] idx; logic [31:0] wd; } wr_t;
   item_t sbq[$];
   wr_t   wq[$];
   logic [31:0] mdl [32];
   logic [31:0] exp_rd = '0;
   int    last_acc = 0;
   bit    mon_en = 1'b0;

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input bit sx);
      logic [31:0] sh;
      if (sz == 2'b00) begin
         sh = w >> (8 * lo);
         return sx ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      end else if (sz == 2'b01) begin
         sh = w >> (16 * lo[1]);
         return sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      end
      return w;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] m;
      m = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * lo);
      return (w & ~m) | ((d << (8 * lo)) & m);
   endfunction

   // Drive one request and wait for acceptance. Then push the expected outcome.
   task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit sx);
      item_t it;
      wr_t   wr;
      int    n;
      int    idx;
      logic [31:0] ea;
      bit    trap;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; size = sz; sign_ext = sx;
      n = 0;
      while (!ready && n < 20) begin @(negedge clk); n++; end
      if (!ready) begin check("accept_timeout", 32'd0, 32'd1); req = 1'b0; return; end
      ea = a;
      if (sz == 2'b01) ea[0] = 1'b0;
      else if (sz[1]) ea[1:0] = 2'b00;
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = (ea != a);
`endif
      idx = int'(ea[6:2]);
      it.acc = cyc;
      it.er  = trap;
      if (trap) begin
         it.lat = 1;
      end else if (!w) begin
         exp_rd = ld_model(mdl[idx], ea[1:0], sz, sx);
         it.lat = 2;
      end else begin
         wr.idx = 32'(idx);
         wr.wd  = sz[1] ? d : st_model(mdl[idx], ea[1:0], sz, d);
         mdl[idx] = wr.wd;
         wq.push_back(wr);
         it.lat = sz[1] ? 2 : 3;
      end
      it.rd = exp_rd;
      sbq.push_back(it);
      last_acc = cyc;
      @(posedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      req = 1'b0;
      while ((sbq.size() != 0 || !ready) && n < 50) begin @(negedge clk); n++; end
      if (sbq.size() != 0) check("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   item_t mit;
   wr_t   mwr;
   always @(negedge clk) begin
      if (mon_en) begin
         if (done) begin
            if (sbq.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else begin
               mit = sbq.pop_front();
               check("rdata", rdata, mit.rd);
               check("err", {31'b0, err}, {31'b0, mit.er});
               check("latency", 32'(cyc - mit.acc), 32'(mit.lat));
            end
         end
         if (mem_we) begin
            if (wq.size() == 0) check("we_unexpected", 32'd1, 32'd0);
            else begin
               mwr = wq.pop_front();
               check("mem_a", mem_a, mwr.idx);
               check("mem_wd", mem_wd, mwr.wd);
            end
         end
      end
   end

   initial begin
      logic [31:0] saved;
      int a1, n;
      for (int i = 0; i < 32; i++) mdl[i] = pat(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      init_en = 1'b0;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      rst = 1'b1;
      mon_en = 1'b1;

      // sw then sb on word 2, followed by the loads from the plan
      do_op(1'b1, 32'h8, 32'hDEADBEEF, 2'b10, 1'b0);
      do_op(1'b1, 32'h9, 32'h55, 2'b00, 1'b0);
      wait_idle();
      check("ram2_after_sb", ram[2], 32'hDEAD55EF);
      do_op(1'b0, 32'hB, 32'h0, 2'b00, 1'b1);
      do_op(1'b0, 32'hB, 32'h0, 2'b00, 1'b0);
      do_op(1'b0, 32'hA, 32'h0, 2'b01, 1'b0);
      wait_idle();
      check("lh_rdata", rdata, 32'h0000DEAD);

      // back-to-back loads with req held high
      do_op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      a1 = last_acc;
      do_op(1'b0, 32'h14, 32'h0, 2'b10, 1'b1);
      check("b2b_gap", 32'(last_acc - a1), 32'd3);
      wait_idle();

      // misaligned accesses
      do_op(1'b0, 32'h6, 32'h0, 2'b10, 1'b0);
      do_op(1'b1, 32'h13, 32'h1234ABCD, 2'b01, 1'b0);
      do_op(1'b0, 32'h13, 32'h0, 2'b01, 1'b1);
      wait_idle();

      // reset while a byte store sits in WR
      mon_en = 1'b0;
      saved = ram[5];
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h15; wdata = 32'hAA; size = 2'b00;
      n = 0;
      while (!mem_we && n < 10) begin @(negedge clk); n++; end
      check("mid_rst_in_wr", {31'b0, mem_we}, 32'd1);
      req = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_we_drop", {31'b0, mem_we}, 32'd0);
      @(posedge clk);
      #1;
      check("mid_rst_ram_kept", ram[5], saved);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post_rst_ready", {31'b0, ready}, 32'd1);
      check("post_rst_rdata", rdata, 32'd0);
      check("post_rst_done", {31'b0, done}, 32'd0);
      sbq.delete();
      wq.delete();
      exp_rd = '0;
      mon_en = 1'b1;

      // random mix, addresses past DEPTH words to exercise wrap
      for (int k = 0; k < 40; k++) begin
         do_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      for (int i = 0; i < 32; i++) check($sformatf("ram[%0d]", i), ram[i], mdl[i]);
      check("wq_empty", 32'(wq.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit that drives the word-addressed data RAM on behalf of the MIPS datapath.
- Converts byte addresses to word indices.
- Performs byte, halfword and word loads with sign or zero extension.
- Implements sub-word stores as read-modify-write, because the RAM only supports whole-word writes.
- Sits between the execute/memory stage and the data RAM; stalls the core via `ready` while a multi-cycle access is in flight.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported because of the 4 byte lanes.
- DEPTH, 32, RAM depth in words; the word index is masked to $clog2(DEPTH) bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- req  in  1  access request from core
- ready  out  1  unit idle; request accepted when req&&ready
- we  in  1  1=store, 0=load
- addr  in  WIDTH  byte address
- wdata  in  WIDTH  store data, right-aligned
- size  in  2  00=byte, 01=half, 10=word, 11=word
- sign_ext  in  1  load: 1=sign-extend, 0=zero-extend
- done  out  1  one-cycle completion pulse
- rdata  out  WIDTH  load result, extended
- err  out  1  misalignment flag, valid with done
- mem_a  out  WIDTH  RAM word index
- mem_wd  out  WIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_rd  in  WIDTH  RAM combinational read data

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - rdata=0, done=0, err=0, mem_we=0, mem_a=0, mem_wd=0; all internal latches cleared.
  - A reset in any state aborts the access; mem_we drops immediately, so no partial write is committed.
- Outputs:
  - ready=1 only in IDLE (decoded from state).
  - mem_a = (latched addr >> 2) & (DEPTH-1), zero-extended to WIDTH.
  - mem_we is asserted only in WR.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - On req&&ready, latch addr/we/wdata/size/sign_ext.
  - Next state: load -> RD; word store -> WR; byte/half store -> RD.
  - req while not ready is ignored; the core must hold req.
- RD:
  - mem_we=0; capture mem_rd into rbuf.
  - Next state: load -> RESP; store -> WR.
- WR:
  - mem_we=1.
  - Word store: mem_wd=wdata.
  - Sub-word store: mem_wd=rbuf with the selected lane(s) replaced.
  - Next state: RESP.
- RESP:
  - done=1 for exactly one cycle.
  - For a load, rdata updates on the edge entering RESP and holds until the next load completes.
  - Next state: IDLE; a new request can be accepted in the following cycle.
- Lanes (little-endian):
  - Byte k occupies bits [8k+7:8k], k=addr[1:0].
  - The halfword occupies bits [15:0] if addr[1]=0, else bits [31:16].
- Loads:
  - The selected byte or half is extended per sign_ext.
  - Word loads ignore sign_ext.
- Latency from the acceptance cycle to done: load = 2 cycles, sw = 2 cycles, sb/sh = 3 cycles.
- Stores never change rdata; err=0 unless the optional feature is enabled.
- Misaligned half/word accesses (default build): the low address bits are forced to 0 (half ignores addr[0], word ignores addr[1:0]).
- Out-of-range word index: wraps modulo DEPTH.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE->RESP directly.
  - No RAM access; mem_we stays 0.
  - done=1 with err=1; rdata is unchanged.
- Undefined: err is tied to 0 and low bits are forced as in Behaviour.

Test Plan:
- Reset mid-sb, while in WR -> mem_we falls to 0 immediately, RAM word unchanged; after release ready=1, rdata=0, done=0.
- sw addr=0x8 wdata=0xDEADBEEF -> mem_a=2, mem_we=1 for one cycle, mem_wd=0xDEADBEEF; done 2 cycles after acceptance.
- RAM[2]=0xDEADBEEF; sb addr=0x9 wdata=0x55 -> RD then WR with mem_wd=0xDEAD55EF; done 3 cycles after acceptance.
- RAM[2]=0xDEAD55EF:
  - lb addr=0xB sign_ext=1 -> rdata=0xFFFFFFDE.
  - lbu -> rdata=0x000000DE.
  - lh addr=0xA sign_ext=0 -> rdata=0x0000DEAD.
- Back-to-back lw requests with req held high -> second accepted the cycle after done; ready low for exactly 2 cycles per load.
- With MISALIGN_TRAP_EN: lw addr=0x6 -> done=1, err=1 one cycle after acceptance, mem_we never set, rdata unchanged. Without the macro: the same request reads RAM[1].
